// File: rtl/traffic_phase_monitor.sv
// Passive checker for the four-approach light controller. It registers the light-code buses,
// follows the six-phase cycle and its dwell time, and reports protocol violations.
module traffic_phase_monitor #(
    parameter int MIN_DWELL = 2,
    parameter int MAX_DWELL = 15,
    parameter int DW_W      = 5,
    parameter int ERR_W     = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       m1,
    input  logic [2:0]       m2,
    input  logic [2:0]       m3,
    input  logic [2:0]       m4,
    input  logic             clr_err,
    output logic             locked,
    output logic [2:0]       phase,
    output logic [DW_W-1:0]  dwell,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] round_count
);
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    localparam logic [2:0] CLS_NONE = 3'd0;
    localparam logic [2:0] CLS_ILL  = 3'd7;

    localparam logic [2:0] E_NONE     = 3'd0;
    localparam logic [2:0] E_CODE     = 3'd1;
    localparam logic [2:0] E_CONFLICT = 3'd2;
    localparam logic [2:0] E_SEQ      = 3'd3;
    localparam logic [2:0] E_SHORT    = 3'd4;
    localparam logic [2:0] E_STALL    = 3'd5;

    localparam logic [DW_W-1:0] DW_ONE = DW_W'(1);
    localparam logic [DW_W-1:0] DW_MIN = DW_W'(MIN_DWELL);
    localparam logic [DW_W-1:0] DW_MAX = DW_W'(MAX_DWELL);
    localparam logic [DW_W-1:0] DW_SAT = DW_W'(MAX_DWELL + 1);

    typedef enum logic {ACQUIRE, LOCKED} state_t;

    logic [3:0][2:0]  m_in;
    logic [3:0][2:0]  m_reg;
    logic [3:0]       bus_legal;
    logic             in_valid_reg;
    state_t           state_reg, state_next;
    logic [2:0]       phase_reg, phase_next;
    logic [DW_W-1:0]  dwell_reg, dwell_next;
    logic [2:0]       cls, succ;
    logic [2:0]       err_code_reg, err_code_next;
    logic             err_valid_reg;
    logic             err_pulse;
    logic             round_inc;
    logic [ERR_W-1:0] err_count_reg;
    logic [CNT_W-1:0] round_count_reg;

    assign m_in = {m4, m3, m2, m1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_legal
            assign bus_legal[gi] = (m_reg[gi] == G) || (m_reg[gi] == Y) || (m_reg[gi] == R);
        end
    endgenerate

    // in_valid_reg keeps the cleared post-reset register from being judged as an illegal code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg        <= '0;
            in_valid_reg <= 1'b0;
        end else begin
            m_reg        <= m_in;
            in_valid_reg <= 1'b1;
        end
    end

    always_comb begin
        cls = CLS_NONE;
        if (bus_legal != 4'b1111) begin
            cls = CLS_ILL;
        end else begin
            case ({m_reg[0], m_reg[1], m_reg[2], m_reg[3]})
                {G, R, R, G}: cls = 3'd1;
                {G, R, R, Y}: cls = 3'd2;
                {G, G, R, R}: cls = 3'd3;
                {Y, Y, R, R}: cls = 3'd4;
                {R, R, G, R}: cls = 3'd5;
                {R, R, Y, R}: cls = 3'd6;
                default:      cls = CLS_NONE;
            endcase
        end
    end

    assign succ = (phase_reg == 3'd6) ? 3'd1 : phase_reg + 3'd1;

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        dwell_next    = dwell_reg;
        err_code_next = E_NONE;
        round_inc     = 1'b0;
        if (in_valid_reg) begin
            case (state_reg)
                ACQUIRE: begin
                    if (cls == CLS_ILL) begin
                        err_code_next = E_CODE;
                    end else if (cls != CLS_NONE) begin
                        state_next = LOCKED;
                        phase_next = cls;
                        dwell_next = DW_ONE;
                    end
                end
                LOCKED: begin
                    if (cls == CLS_ILL || cls == CLS_NONE) begin
                        err_code_next = (cls == CLS_ILL) ? E_CODE : E_CONFLICT;
                        state_next    = ACQUIRE;
                        phase_next    = 3'd0;
                        dwell_next    = '0;
                    end else if (cls == phase_reg) begin
                        // Stall is reported only on the step into saturation.
                        if (dwell_reg != DW_SAT) begin
                            dwell_next = dwell_reg + DW_ONE;
                            if (dwell_reg == DW_MAX) begin
                                err_code_next = E_STALL;
                            end
                        end
                    end else if (cls == succ) begin
                        if (dwell_reg < DW_MIN) begin
                            err_code_next = E_SHORT;
                        end
                        round_inc  = (phase_reg == 3'd6);
                        phase_next = cls;
                        dwell_next = DW_ONE;
                    end else begin
                        err_code_next = E_SEQ;
                        phase_next    = cls;
                        dwell_next    = DW_ONE;
                    end
                end
                default: state_next = ACQUIRE;
            endcase
        end
    end

    assign err_pulse = (err_code_next != E_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ACQUIRE;
            phase_reg       <= 3'd0;
            dwell_reg       <= '0;
            err_valid_reg   <= 1'b0;
            err_code_reg    <= E_NONE;
            err_count_reg   <= '0;
            round_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            dwell_reg     <= dwell_next;
            err_valid_reg <= err_pulse;
            err_code_reg  <= err_code_next;
            if (round_inc) begin
                round_count_reg <= round_count_reg + CNT_W'(1);
            end
            // A clear that coincides with a new error leaves that error counted.
            if (clr_err) begin
                err_count_reg <= err_pulse ? ERR_W'(1) : '0;
            end else if (err_pulse && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + ERR_W'(1);
            end
        end
    end

    assign locked      = (state_reg == LOCKED);
    assign phase       = phase_reg;
    assign dwell       = dwell_reg;
    assign err_valid   = err_valid_reg;
    assign err_code    = err_code_reg;
    assign err_count   = err_count_reg;
    assign round_count = round_count_reg;
endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Bench for traffic_phase_monitor: table-driven phase cycle, directed corner cases and
// randomized bursts, all compared against an abstract reference model.
module tb_traffic_phase_monitor;
    localparam int MIN_D = 2;
    localparam int MAX_D = 15;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] m1 = '0, m2 = '0, m3 = '0, m4 = '0;
    logic       clr_err = 1'b0;

    logic       locked, locked2;
    logic [2:0] phase, phase2;
    logic [4:0] dwell, dwell2;
    logic       err_valid, err_valid2;
    logic [2:0] err_code, err_code2;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    logic [7:0] round_count, round_count2;

    traffic_phase_monitor dut (
        .clk(clk), .rst(rst), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .clr_err(clr_err),
        .locked(locked), .phase(phase), .dwell(dwell), .err_valid(err_valid),
        .err_code(err_code), .err_count(err_count), .round_count(round_count)
    );

    traffic_phase_monitor #(.ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .clr_err(clr_err),
        .locked(locked2), .phase(phase2), .dwell(dwell2), .err_valid(err_valid2),
        .err_code(err_code2), .err_count(err_count2), .round_count(round_count2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [11:0] pat_tbl [1:6];
    logic [2:0]  bad_codes [5];
    logic [2:0]  good_codes [3];

    // Reference model state
    int mlocked, mphase, mdwell, merr, mcount, mcount2, mround;
    logic [11:0] pend;
    bit pend_valid;

    typedef struct {
        int k;
        int reps;
        int lk;
        int ph;
        int dw;
        int ec;
        int rnd;
    } vec_t;
    vec_t vecs [7];

    function automatic int classify(logic [11:0] v);
        logic [2:0] c;
        for (int i = 0; i < 4; i++) begin
            c = v[3*i +: 3];
            if (!(c == G || c == Y || c == R)) return -1;
        end
        for (int k = 1; k <= 6; k++) begin
            if (v == pat_tbl[k]) return k;
        end
        return 0;
    endfunction

    task automatic model_reset();
        mlocked = 0; mphase = 0; mdwell = 0; merr = 0;
        mcount = 0; mcount2 = 0; mround = 0;
        pend = '0; pend_valid = 0;
    endtask

    task automatic model_step();
        int c;
        int e;
        e = 0;
        if (pend_valid) begin
            c = classify(pend);
            if (mlocked == 0) begin
                if (c < 0) e = 1;
                else if (c > 0) begin mlocked = 1; mphase = c; mdwell = 1; end
            end else if (c <= 0) begin
                e = (c < 0) ? 1 : 2;
                mlocked = 0; mphase = 0; mdwell = 0;
            end else if (c == mphase) begin
                if (mdwell < MAX_D + 1) begin
                    mdwell = mdwell + 1;
                    if (mdwell == MAX_D + 1) e = 5;
                end
            end else if (c == (mphase % 6) + 1) begin
                if (mdwell < MIN_D) e = 4;
                if (mphase == 6) mround = (mround + 1) % 256;
                mphase = c; mdwell = 1;
            end else begin
                e = 3; mphase = c; mdwell = 1;
            end
        end
        merr = e;
        if (clr_err) begin
            mcount  = (e != 0) ? 1 : 0;
            mcount2 = (e != 0) ? 1 : 0;
        end else if (e != 0) begin
            if (mcount < 255) mcount = mcount + 1;
            if (mcount2 < 3) mcount2 = mcount2 + 1;
        end
        pend = {m1, m2, m3, m4};
        pend_valid = 1;
    endtask

    task automatic check_eq(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        logic [28:0] act1, exp1;
        logic [22:0] act2, exp2;
        act1 = {locked, phase, dwell, err_valid, err_code, err_count, round_count};
        exp1 = {1'(mlocked), 3'(mphase), 5'(mdwell), 1'(merr != 0), 3'(merr), 8'(mcount), 8'(mround)};
        act2 = {locked2, phase2, dwell2, err_valid2, err_code2, err_count2, round_count2};
        exp2 = {1'(mlocked), 3'(mphase), 5'(mdwell), 1'(merr != 0), 3'(merr), 2'(mcount2), 8'(mround)};
        tests++;
        if (act1 !== exp1) begin
            fails++;
            $display("FAIL %s model: got lk=%0d ph=%0d dw=%0d ev=%0d ec=%0d cnt=%0d rnd=%0d, expected lk=%0d ph=%0d dw=%0d ev=%0d ec=%0d cnt=%0d rnd=%0d",
                     tag, locked, phase, dwell, err_valid, err_code, err_count, round_count,
                     mlocked, mphase, mdwell, merr != 0, merr, mcount, mround);
        end
        tests++;
        if (act2 !== exp2) begin
            fails++;
            $display("FAIL %s model_w2: got 0x%0h, expected 0x%0h", tag, act2, exp2);
        end
    endtask

    task automatic tick(logic [11:0] v, logic clr, string tag);
        {m1, m2, m3, m4} = v;
        clr_err = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset(string tag);
        #2 rst = 1'b1;
        #1;
        check_eq({tag, "_async_zero"},
                 int'({locked, phase, dwell, err_valid, err_code, err_count, round_count}), 0);
        check_eq({tag, "_async_zero_w2"},
                 int'({locked2, phase2, dwell2, err_valid2, err_code2, err_count2, round_count2}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_vec(int j);
        check_eq($sformatf("vec%0d_state", j),
                 int'({locked, phase, dwell, err_code, round_count}),
                 int'({1'(vecs[j].lk), 3'(vecs[j].ph), 5'(vecs[j].dw), 3'(vecs[j].ec), 8'(vecs[j].rnd)}));
    endtask

    initial begin
        logic [11:0] ill_pat, conf_pat, allr_pat, v;
        int saw_err, pulses, pulse_dw, pulse_ec, cur_k, sel, n, idx;
        logic clr;

        pat_tbl[1] = {G, R, R, G};
        pat_tbl[2] = {G, R, R, Y};
        pat_tbl[3] = {G, G, R, R};
        pat_tbl[4] = {Y, Y, R, R};
        pat_tbl[5] = {R, R, G, R};
        pat_tbl[6] = {R, R, Y, R};
        bad_codes  = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd7};
        good_codes = '{G, Y, R};
        ill_pat  = {R, R, 3'b101, R};
        conf_pat = {G, R, G, R};
        allr_pat = {R, R, R, R};

        // {phase, repeats, locked, phase, dwell, err_code, round_count} after each burst
        vecs[0] = '{1, 8, 1, 1, 8, 0, 0};
        vecs[1] = '{2, 3, 1, 2, 3, 0, 0};
        vecs[2] = '{3, 4, 1, 3, 4, 0, 0};
        vecs[3] = '{4, 3, 1, 4, 3, 0, 0};
        vecs[4] = '{5, 5, 1, 5, 5, 0, 0};
        vecs[5] = '{6, 3, 1, 6, 3, 0, 0};
        vecs[6] = '{1, 1, 1, 1, 1, 0, 1};

        model_reset();
        @(negedge clk);
        check_eq("reset_state",
                 int'({locked, phase, dwell, err_valid, err_code, err_count, round_count}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full signalling cycle
        saw_err = 0;
        for (int j = 0; j < 7; j++) begin
            $display("[TB] vec %0d: P%0d x%0d", j, vecs[j].k, vecs[j].reps);
            for (int r = 0; r < vecs[j].reps; r++) begin
                tick(pat_tbl[vecs[j].k], 1'b0, "cycle");
                if (err_valid) saw_err = 1;
                if (j == 0 && r == 0) check_eq("lock_edge1", int'(locked), 0);
                if (j == 0 && r == 1) check_eq("lock_edge2", int'(locked), 1);
                if (j > 0 && r == 0) check_vec(j - 1);
            end
        end
        tick(pat_tbl[1], 1'b0, "cycle_flush");
        check_vec(6);
        check_eq("cycle_no_err", saw_err | int'(err_valid), 0);
        check_eq("cycle_err_count", int'(err_count), 0);

        // Illegal code while locked in P6, then relock on P1
        do_reset("pre_ill");
        $display("[TB] seq: illegal code in P6");
        for (int r = 0; r < 3; r++) tick(pat_tbl[6], 1'b0, "p6");
        tick(ill_pat, 1'b0, "ill");
        tick(pat_tbl[1], 1'b0, "after_ill");
        check_eq("ill_pulse", int'({err_valid, err_code, locked, phase, err_count}),
                 int'({1'b1, 3'd1, 1'b0, 3'd0, 8'd1}));
        tick(pat_tbl[1], 1'b0, "relock");
        check_eq("relock", int'({err_valid, locked, phase}), int'({1'b0, 1'b1, 3'd1}));

        // Out-of-order jump P1 (dwell 3) -> P5
        $display("[TB] seq: P1 dwell 3 then P5");
        tick(pat_tbl[1], 1'b0, "p1");
        tick(pat_tbl[5], 1'b0, "p5_a");
        check_eq("p1_dwell3", int'({phase, dwell}), int'({3'd1, 5'd3}));
        tick(pat_tbl[5], 1'b0, "p5_b");
        check_eq("seq_err", int'({err_valid, err_code, locked, phase, dwell}),
                 int'({1'b1, 3'd3, 1'b1, 3'd5, 5'd1}));

        // Stall on a long P1 hold
        do_reset("pre_stall");
        $display("[TB] seq: P1 held 20 cycles");
        pulses = 0; pulse_dw = 0; pulse_ec = 0;
        for (int r = 0; r < 21; r++) begin
            tick(pat_tbl[1], 1'b0, "stall");
            if (err_valid) begin
                pulses++;
                pulse_dw = int'(dwell);
                pulse_ec = int'(err_code);
            end
        end
        check_eq("stall_pulses", pulses, 1);
        check_eq("stall_pulse_at", int'({3'(pulse_ec), 5'(pulse_dw)}), int'({3'd5, 5'd16}));
        check_eq("stall_hold", int'({dwell, err_count}), int'({5'd16, 8'd1}));

        // Short phase, then conflicting greens
        $display("[TB] seq: P1 x4, P2 x1, P3");
        for (int r = 0; r < 3; r++) tick(pat_tbl[1], 1'b0, "short_p1");
        tick(pat_tbl[2], 1'b0, "short_p2");
        tick(pat_tbl[3], 1'b0, "short_p3a");
        tick(pat_tbl[3], 1'b0, "short_p3b");
        check_eq("short_err", int'({err_valid, err_code, phase, dwell}),
                 int'({1'b1, 3'd4, 3'd3, 5'd1}));
        $display("[TB] seq: conflicting greens");
        tick(conf_pat, 1'b0, "conf");
        tick(pat_tbl[3], 1'b0, "after_conf");
        check_eq("conf_err", int'({err_valid, err_code, locked, phase, err_count}),
                 int'({1'b1, 3'd2, 1'b0, 3'd0, 8'd3}));

        // Reset in the middle of P3
        $display("[TB] seq: reset mid-P3");
        for (int r = 0; r < 3; r++) tick(pat_tbl[3], 1'b0, "mid_p3");
        do_reset("mid_p3");
        tick(pat_tbl[3], 1'b0, "post_rst1");
        check_eq("post_rst_no_pulse", int'({err_valid, locked}), 0);
        tick(pat_tbl[3], 1'b0, "post_rst2");
        check_eq("post_rst_lock", int'({err_valid, locked, phase, dwell}),
                 int'({1'b0, 1'b1, 3'd3, 5'd1}));

        // Error counter saturation and clear
        do_reset("pre_cnt");
        $display("[TB] seq: error counting and clear");
        for (int r = 0; r < 6; r++) tick(ill_pat, 1'b0, "cnt_ill");
        check_eq("cnt_five", int'(err_count), 5);
        check_eq("cnt_sat_w2", int'(err_count2), 3);
        tick(allr_pat, 1'b1, "clr_with_pulse");
        check_eq("clr_with_pulse", int'({err_valid, err_count, err_count2}),
                 int'({1'b1, 8'd1, 2'd1}));
        tick(allr_pat, 1'b1, "clr_alone");
        check_eq("clr_alone", int'({err_valid, err_count, err_count2}), 0);
        tick(allr_pat, 1'b0, "idle");

        // Randomized bursts
        do_reset("pre_rand");
        cur_k = 1;
        for (int b = 0; b < 70; b++) begin
            sel = $urandom_range(0, 99);
            n   = $urandom_range(1, 18);
            clr = ($urandom_range(0, 9) == 0);
            if (sel < 65) begin
                cur_k = (cur_k % 6) + 1;
                v = pat_tbl[cur_k];
            end else if (sel < 78) begin
                cur_k = $urandom_range(1, 6);
                v = pat_tbl[cur_k];
            end else if (sel < 88) begin
                v = pat_tbl[cur_k];
                idx = $urandom_range(0, 3);
                v[3*idx +: 3] = bad_codes[$urandom_range(0, 4)];
                n = $urandom_range(1, 2);
            end else begin
                for (int i = 0; i < 4; i++) v[3*i +: 3] = good_codes[$urandom_range(0, 2)];
                n = $urandom_range(1, 3);
            end
            $display("[TB] rand %0d: m=%03h x%0d clr=%0d", b, v, n, clr);
            for (int r = 0; r < n; r++) tick(v, clr && (r == 0), "rand");
            if (sel >= 96) do_reset("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
